// File: rtl/tl_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tl_ctrl_pkg
// Shared definitions for the TileLink control-register responder: A/D channel
// opcode constants, the response entry carried through the response queue,
// and a byte-merge helper used for masked register writes.
// No ports (package).
// ---------------------------------------------------------------------------
package tl_ctrl_pkg;

  // A-channel request opcodes
  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_ARITHMETIC  = 3'd2;
  localparam logic [2:0] A_LOGICAL     = 3'd3;
  localparam logic [2:0] A_GET         = 3'd4;

  // D-channel response opcodes
  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

  // One queued response, exactly the D payload that will be presented
  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  size;
    logic [11:0] source;
    logic        denied;
    logic [63:0] data;
  } respEntry_t;

  // Replace each byte of oldValue whose mask bit is set with the matching
  // byte of newValue; used for both PutFullData and PutPartialData.
  function automatic logic [63:0] mergeBytes(input logic [63:0] oldValue,
                                             input logic [63:0] newValue,
                                             input logic [7:0]  mask);
    logic [63:0] result;
    result = oldValue;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) result[8*i +: 8] = newValue[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/tl_ctrl_responder_if.sv
// ---------------------------------------------------------------------------
// tl_ctrl_responder_if
// TileLink-UL A/D channel bundle between a requester (master) and the
// control-register responder (slave).
//   A channel : valid/ready, opcode, size, source, address, mask, data, corrupt
//   D channel : valid/ready, opcode, size, source, denied, data
// ---------------------------------------------------------------------------
interface tl_ctrl_responder_if;

  logic        auto_in_a_valid;
  logic        auto_in_a_ready;
  logic [2:0]  auto_in_a_bits_opcode;
  logic [1:0]  auto_in_a_bits_size;
  logic [11:0] auto_in_a_bits_source;
  logic [30:0] auto_in_a_bits_address;
  logic [7:0]  auto_in_a_bits_mask;
  logic [63:0] auto_in_a_bits_data;
  logic        auto_in_a_bits_corrupt;

  logic        auto_in_d_valid;
  logic        auto_in_d_ready;
  logic [2:0]  auto_in_d_bits_opcode;
  logic [1:0]  auto_in_d_bits_size;
  logic [11:0] auto_in_d_bits_source;
  logic        auto_in_d_bits_denied;
  logic [63:0] auto_in_d_bits_data;

  // Requester side: issues A beats, accepts D beats
  modport master (
    output auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_size,
           auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
           auto_in_a_bits_data, auto_in_a_bits_corrupt, auto_in_d_ready,
    input  auto_in_a_ready, auto_in_d_valid, auto_in_d_bits_opcode,
           auto_in_d_bits_size, auto_in_d_bits_source, auto_in_d_bits_denied,
           auto_in_d_bits_data
  );

  // Responder side: accepts A beats, issues D beats
  modport slave (
    input  auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_size,
           auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
           auto_in_a_bits_data, auto_in_a_bits_corrupt, auto_in_d_ready,
    output auto_in_a_ready, auto_in_d_valid, auto_in_d_bits_opcode,
           auto_in_d_bits_size, auto_in_d_bits_source, auto_in_d_bits_denied,
           auto_in_d_bits_data
  );

endinterface

// File: rtl/tl_resp_queue.sv
// ---------------------------------------------------------------------------
// tl_resp_queue
// Two-entry in-order FIFO of response entries. No flow-through: an entry
// written on one edge is visible at the output only after that edge.
// Ports:
//   clock, reset              : clock and synchronous active-low reset
//   enqValid_i / enqReady_o   : push request / room available (count != 2)
//   enqEntry_i                : entry to push
//   deqValid_o / deqReady_i   : head valid (count != 0) / head consumed
//   deqEntry_o                : head entry, all zeros while empty
// ---------------------------------------------------------------------------
module tl_resp_queue
  import tl_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       enqValid_i,
  output logic       enqReady_o,
  input  respEntry_t enqEntry_i,
  output logic       deqValid_o,
  input  logic       deqReady_i,
  output respEntry_t deqEntry_o
);

  respEntry_t entries_q [2];
  logic       wrPtr_q;
  logic       rdPtr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       push;
  logic       pop;

  // Ready and valid come straight from the occupancy register, so the
  // consumer's ready never reaches the producer's ready combinationally.
  assign enqReady_o = (count_q != 2'd2);
  assign deqValid_o = (count_q != 2'd0);
  assign deqEntry_o = deqValid_o ? entries_q[rdPtr_q] : '0;
  assign push       = enqValid_i && enqReady_o;
  assign pop        = deqValid_o && deqReady_i;

  // Occupancy bookkeeping: a simultaneous push and pop leaves the count
  // unchanged, only the pointers move.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Entry storage needs no reset; the occupancy count decides what is live.
  always_ff @(posedge clock) begin
    if (push) entries_q[wrPtr_q] <= enqEntry_i;
  end

  // Pointers and count, cleared by reset so queued responses are dropped.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) wrPtr_q <= ~wrPtr_q;
      if (pop)  rdPtr_q <= ~rdPtr_q;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tl_ctrl_responder.sv
// ---------------------------------------------------------------------------
// tl_ctrl_responder
// TileLink-UL slave exposing NUM_REGS 64-bit control registers at BASE_ADDR.
// Gets return a snapshot of the register at accept time, Puts perform
// byte-masked writes, anything unsupported or outside the region gets a
// denied response. Responses are queued in order in a 2-entry FIFO.
// Ports:
//   clock : sole clock, rising edge
//   reset : synchronous active-low reset
//   bus   : A/D channel bundle (slave modport)
// ---------------------------------------------------------------------------
module tl_ctrl_responder
  import tl_ctrl_pkg::*;
#(
  parameter logic [30:0] BASE_ADDR = 31'h0200_0000,
  parameter int          NUM_REGS  = 8
)(
  input  logic                 clock,
  input  logic                 reset,
  tl_ctrl_responder_if.slave   bus
);

  localparam logic [3:0] NUM_REGS_L = 4'(NUM_REGS);

  logic [63:0] regs_q [NUM_REGS];
  logic [63:0] regs_d [NUM_REGS];
  logic [2:0]  regIdx;
  logic        regHit;
  logic        queueReady;
  logic        aFire;
  logic        writeEn;
  respEntry_t  newResp;
  respEntry_t  headResp;
  logic        unusedAddrBits;

  // Byte offset inside a register is not part of the decode.
  assign unusedAddrBits = ^bus.auto_in_a_bits_address[2:0];

  // Decode the A beat and build its response. Size is only two bits wide,
  // so it can never exceed the 8-byte register width and needs no check.
  always_comb begin
    regIdx  = bus.auto_in_a_bits_address[5:3];
    regHit  = (bus.auto_in_a_bits_address[30:6] == BASE_ADDR[30:6]) &&
              ({1'b0, regIdx} < NUM_REGS_L);
    aFire   = bus.auto_in_a_valid && queueReady;
    writeEn = 1'b0;
    newResp        = '0;
    newResp.size   = bus.auto_in_a_bits_size;
    newResp.source = bus.auto_in_a_bits_source;
    case (bus.auto_in_a_bits_opcode)
      A_GET: begin
        newResp.opcode = D_ACCESS_ACK_DATA;
        if (regHit) newResp.data   = regs_q[regIdx];
        else        newResp.denied = 1'b1;
      end
      A_PUT_FULL, A_PUT_PARTIAL: begin
        newResp.opcode = D_ACCESS_ACK;
        if (regHit && !bus.auto_in_a_bits_corrupt) writeEn = 1'b1;
        else                                       newResp.denied = 1'b1;
      end
      A_ARITHMETIC, A_LOGICAL: begin
        newResp.opcode = D_ACCESS_ACK_DATA;
        newResp.denied = 1'b1;
      end
      default: begin
        newResp.opcode = D_ACCESS_ACK;
        newResp.denied = 1'b1;
      end
    endcase
  end

  // Next register contents: only the addressed register changes, and only
  // the bytes enabled by the mask.
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) regs_d[k] = regs_q[k];
    if (aFire && writeEn) begin
      regs_d[regIdx] = mergeBytes(regs_q[regIdx], bus.auto_in_a_bits_data,
                                  bus.auto_in_a_bits_mask);
    end
  end

  // Register file; reset wins over any write arriving in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
    end
  end

  tl_resp_queue u_respQueue (
    .clock      (clock),
    .reset      (reset),
    .enqValid_i (bus.auto_in_a_valid),
    .enqReady_o (queueReady),
    .enqEntry_i (newResp),
    .deqValid_o (bus.auto_in_d_valid),
    .deqReady_i (bus.auto_in_d_ready),
    .deqEntry_o (headResp)
  );

  assign bus.auto_in_a_ready       = queueReady;
  assign bus.auto_in_d_bits_opcode = headResp.opcode;
  assign bus.auto_in_d_bits_size   = headResp.size;
  assign bus.auto_in_d_bits_source = headResp.source;
  assign bus.auto_in_d_bits_denied = headResp.denied;
  assign bus.auto_in_d_bits_data   = headResp.data;

endmodule

// File: tb/tb_tl_ctrl_responder.sv
// ---------------------------------------------------------------------------
// tb_tl_ctrl_responder
// Scoreboard bench for tl_ctrl_responder: directed scenarios followed by
// randomized traffic, expected responses produced by a register-array model.
// ---------------------------------------------------------------------------
module tb_tl_ctrl_responder;

  localparam logic [30:0] BASE  = 31'h0200_0000;
  localparam int          NREGS = 8;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  size;
    logic [11:0] source;
    logic        denied;
    logic [63:0] data;
  } expResp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  expResp_t    sb [$];
  logic [63:0] modelRegs [NREGS];
  int          checksTotal  = 0;
  int          checksPassed = 0;
  int          readyMode    = 1;
  logic [2:0]  opTable [13] = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd4, 3'd0, 3'd1,
                                3'd4, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

  // Free-running clock, period 10
  always #5 clock = ~clock;

  tl_ctrl_responder_if bus ();

  tl_ctrl_responder #(.BASE_ADDR(BASE), .NUM_REGS(NREGS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input logic [81:0] actual,
                             input logic [81:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Behavioural model: what a TileLink register block answers, updating
  // the register array on successful writes.
  task automatic modelAccept(input logic [2:0] op, input logic [1:0] size,
                             input logic [11:0] src, input logic [30:0] addr,
                             input logic [7:0] mask, input logic [63:0] data,
                             input logic corrupt, output expResp_t r);
    int  idx;
    bit  inRegion;
    bit  isGet, isPut, wantsData;
    idx       = int'(addr[5:3]);
    inRegion  = (addr[30:6] == BASE[30:6]) && (idx < NREGS);
    isGet     = (op == 3'd4);
    isPut     = (op == 3'd0) || (op == 3'd1);
    wantsData = isGet || (op == 3'd2) || (op == 3'd3);
    r         = '0;
    r.size    = size;
    r.source  = src;
    r.opcode  = wantsData ? 3'd1 : 3'd0;
    if (isGet && inRegion) begin
      r.data = modelRegs[idx];
    end else if (isPut && inRegion && !corrupt) begin
      for (int b = 0; b < 8; b++)
        if (mask[b]) modelRegs[idx][8*b +: 8] = data[8*b +: 8];
    end else begin
      r.denied = 1'b1;
    end
  endtask

  // Present one A beat until accepted (bounded), then record its response.
  task automatic applyStimulus(input logic [2:0] op, input logic [1:0] size,
                               input logic [11:0] src, input logic [30:0] addr,
                               input logic [7:0] mask, input logic [63:0] data,
                               input logic corrupt);
    logic     rdy;
    bit       accepted;
    expResp_t r;
    bus.auto_in_a_valid        = 1'b1;
    bus.auto_in_a_bits_opcode  = op;
    bus.auto_in_a_bits_size    = size;
    bus.auto_in_a_bits_source  = src;
    bus.auto_in_a_bits_address = addr;
    bus.auto_in_a_bits_mask    = mask;
    bus.auto_in_a_bits_data    = data;
    bus.auto_in_a_bits_corrupt = corrupt;
    accepted = 1'b0;
    for (int c = 0; c < 100 && !accepted; c++) begin
      @(negedge clock);
      rdy = bus.auto_in_a_ready;
      @(posedge clock);
      if (rdy === 1'b1) accepted = 1'b1;
      #1;
    end
    bus.auto_in_a_valid = 1'b0;
    checkOutput("a_accept", 82'(accepted), 82'd1);
    if (accepted) begin
      modelAccept(op, size, src, addr, mask, data, corrupt, r);
      sb.push_back(r);
    end
  endtask

  // Let every outstanding response drain, bounded.
  task automatic drainResponses();
    readyMode = 1;
    for (int c = 0; c < 60 && (sb.size() != 0 || bus.auto_in_d_valid !== 1'b0); c++) begin
      @(posedge clock);
      #1;
    end
    checkOutput("drain_outstanding", 82'(sb.size()), 82'd0);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // D-ready driver: held low, held high, or random per cycle
  initial begin
    bus.auto_in_d_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (readyMode)
        0:       bus.auto_in_d_ready = 1'b0;
        1:       bus.auto_in_d_ready = 1'b1;
        default: bus.auto_in_d_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare every D beat against the scoreboard head and check
  // that a stalled payload stays put.
  initial begin
    expResp_t cur;
    expResp_t holdPayload;
    bit       holdValid;
    holdValid = 1'b0;
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && bus.auto_in_d_valid === 1'b1) begin
        cur = {bus.auto_in_d_bits_opcode, bus.auto_in_d_bits_size,
               bus.auto_in_d_bits_source, bus.auto_in_d_bits_denied,
               bus.auto_in_d_bits_data};
        if (holdValid) checkOutput("d_stable", cur, holdPayload);
        if (bus.auto_in_d_ready === 1'b1) begin
          if (sb.size() == 0) begin
            checksTotal++;
            $display("[TB] FAIL d_unexpected: got response 0x%0h, expected none", cur);
          end else begin
            checkOutput("d_resp", cur, sb.pop_front());
          end
          holdValid = 1'b0;
        end else begin
          holdValid   = 1'b1;
          holdPayload = cur;
        end
      end else begin
        holdValid = 1'b0;
      end
    end
  end

  // Main sequence: reset, directed scenarios, random traffic, mid-run reset
  initial begin
    logic [30:0] addr;
    int unsigned r;
    bus.auto_in_a_valid        = 1'b0;
    bus.auto_in_a_bits_opcode  = '0;
    bus.auto_in_a_bits_size    = '0;
    bus.auto_in_a_bits_source  = '0;
    bus.auto_in_a_bits_address = '0;
    bus.auto_in_a_bits_mask    = '0;
    bus.auto_in_a_bits_data    = '0;
    bus.auto_in_a_bits_corrupt = 1'b0;
    for (int k = 0; k < NREGS; k++) modelRegs[k] = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_a_ready", 82'(bus.auto_in_a_ready), 82'd1);
    checkOutput("rst_d_valid", 82'(bus.auto_in_d_valid), 82'd0);
    checkOutput("rst_d_payload", {bus.auto_in_d_bits_opcode, bus.auto_in_d_bits_size,
                bus.auto_in_d_bits_source, bus.auto_in_d_bits_denied,
                bus.auto_in_d_bits_data}, 82'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Full and partial writes, read-back, low address bits ignored
    applyStimulus(3'd0, 2'd3, 12'h05A, 31'h0200_0008, 8'hFF, 64'h1122_3344_5566_7788, 1'b0);
    applyStimulus(3'd4, 2'd3, 12'h05A, 31'h0200_0008, 8'h00, 64'h0, 1'b0);
    applyStimulus(3'd1, 2'd3, 12'h011, 31'h0200_0008, 8'h0F, 64'hFFFF_FFFF_AAAA_BBBB, 1'b0);
    applyStimulus(3'd4, 2'd3, 12'h012, 31'h0200_000F, 8'h00, 64'h0, 1'b0);

    // Miss, unsupported atomics, poisoned write; registers must not change
    applyStimulus(3'd4, 2'd3, 12'h0A1, 31'h0300_0000, 8'h00, 64'h0, 1'b0);
    applyStimulus(3'd2, 2'd3, 12'h0A2, 31'h0200_0008, 8'hFF, 64'h5555_5555_5555_5555, 1'b0);
    applyStimulus(3'd0, 2'd3, 12'h0A3, 31'h0200_0010, 8'hFF, 64'hCAFE_CAFE_CAFE_CAFE, 1'b1);
    applyStimulus(3'd4, 2'd2, 12'h0A4, 31'h0200_0008, 8'h00, 64'h0, 1'b0);
    applyStimulus(3'd4, 2'd1, 12'h0A5, 31'h0200_0010, 8'h00, 64'h0, 1'b0);
    drainResponses();

    // Back-pressure: two Gets fill the queue, the third waits for D
    readyMode = 0;
    idleCycles(2);
    applyStimulus(3'd4, 2'd3, 12'h101, 31'h0200_0008, 8'h00, 64'h0, 1'b0);
    applyStimulus(3'd4, 2'd3, 12'h102, 31'h0200_0010, 8'h00, 64'h0, 1'b0);
    @(negedge clock);
    checkOutput("a_ready_full", 82'(bus.auto_in_a_ready), 82'd0);
    @(posedge clock);
    #1;
    readyMode = 1;
    applyStimulus(3'd4, 2'd3, 12'h103, 31'h0200_0008, 8'h00, 64'h0, 1'b0);
    drainResponses();

    // Queued Get keeps its snapshot across a later write to the same register
    readyMode = 0;
    idleCycles(2);
    applyStimulus(3'd4, 2'd3, 12'h201, 31'h0200_0018, 8'h00, 64'h0, 1'b0);
    applyStimulus(3'd0, 2'd3, 12'h202, 31'h0200_0018, 8'hFF, 64'h0000_0000_0000_DEAD, 1'b0);
    readyMode = 1;
    applyStimulus(3'd4, 2'd3, 12'h203, 31'h0200_0018, 8'h00, 64'h0, 1'b0);
    drainResponses();

    // Randomized traffic with random D back-pressure and idle gaps
    readyMode = 2;
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 9);
      if (r < 8) addr = {BASE[30:6], 3'(r), 3'($urandom_range(0, 7))};
      else       addr = 31'($urandom);
      applyStimulus(opTable[$urandom_range(0, 12)], 2'($urandom_range(0, 3)),
                    12'($urandom), addr, 8'($urandom), {$urandom, $urandom},
                    1'($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) idleCycles(int'($urandom_range(1, 3)));
    end
    drainResponses();

    // Reset with two responses queued: queue and registers are cleared
    readyMode = 0;
    idleCycles(2);
    applyStimulus(3'd0, 2'd3, 12'h301, 31'h0200_0028, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0);
    applyStimulus(3'd4, 2'd3, 12'h302, 31'h0200_0028, 8'h00, 64'h0, 1'b0);
    reset = 1'b0;
    sb.delete();
    @(posedge clock);
    @(negedge clock);
    checkOutput("midrst_d_valid", 82'(bus.auto_in_d_valid), 82'd0);
    checkOutput("midrst_a_ready", 82'(bus.auto_in_a_ready), 82'd1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int k = 0; k < NREGS; k++) modelRegs[k] = '0;
    readyMode = 1;
    for (int k = 0; k < NREGS; k++)
      applyStimulus(3'd4, 2'd3, 12'(12'h400 + k), BASE + 31'(8 * k), 8'h00, 64'h0, 1'b0);
    drainResponses();

    $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
